spatz_xmem_responder: RTL

SPATZ_XMEM_RESPONDER -- requirements
Module: spatz_xmem_responder

---
 rtl/spatz_xmem_responder_pkg.sv | 21 ++
 rtl/spatz_xmem_responder_fifo.sv | 74 +++++++
 rtl/spatz_xmem_responder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/spatz_xmem_responder_pkg.sv
// Shared widths and helpers for the Spatz X-interface memory responder.
package spatz_xmem_responder_pkg;

   // Element width of the vector unit; sets the default data path width.
   localparam int unsigned ELEN = 32;

   // Default number of requests that may wait for a memory response.
   localparam int unsigned NrOutstandingDef = 8;

   // Default address width of the memory port.
   localparam int unsigned AddrWidthDef = 32;

   // Index width for a structure of n entries; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Default request/result ID width: enough to name every outstanding slot.
   localparam int unsigned IdWidthDef = idx_width(NrOutstandingDef);

endpackage

// File: rtl/spatz_xmem_responder_fifo.sv
// Tracking FIFO: remembers {id, we, last} of each granted request until its
// memory response retires. Storage is a circular buffer with wrap pointers.
module spatz_xmem_responder_fifo
   import spatz_xmem_responder_pkg::*;
#(
   parameter int unsigned Depth = 8,
   parameter int unsigned Width = 5
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int unsigned PtrWidth = idx_width(Depth);
   localparam int unsigned CntWidth = $clog2(Depth + 1);

   logic [Width-1:0]    storage_q [Depth];
   logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntWidth-1:0] count_q, count_d;
   logic                push_ok, pop_ok;

   // Advance a pointer by one slot, wrapping at the configured depth.
   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
      return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CntWidth'(Depth));
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign data_o  = storage_q[rd_ptr_q];

   // Next-state of the pointers and occupancy count.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers; reset empties the FIFO.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are only meaningful while the count covers them.
   // NOTE: storage is deliberately not reset -- the pointers/count define validity.
   always_ff @(posedge clk_i) begin
      if (push_ok) storage_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/spatz_xmem_responder.sv
// Spatz X-interface memory responder: forwards vector memory requests to a
// memory port, tracks granted requests in order, and returns load results
// (and last-of-operation completion) one cycle after each memory response.
module spatz_xmem_responder
   import spatz_xmem_responder_pkg::*;
#(
   parameter int unsigned DataWidth     = ELEN,
   parameter int unsigned NrOutstanding = NrOutstandingDef,
   parameter int unsigned IdWidth       = IdWidthDef,
   parameter int unsigned AddrWidth     = AddrWidthDef
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   // X-interface request
   input  logic                   x_mem_valid_i,
   output logic                   x_mem_ready_o,
   input  logic [IdWidth-1:0]     req_id_i,
   input  logic [AddrWidth-1:0]   req_addr_i,
   input  logic                   req_we_i,
   input  logic [DataWidth/8-1:0] req_strb_i,
   input  logic [DataWidth-1:0]   req_wdata_i,
   input  logic                   req_last_i,
   // Memory port
   output logic                   mem_req_o,
   input  logic                   mem_gnt_i,
   output logic [AddrWidth-1:0]   mem_addr_o,
   output logic                   mem_we_o,
   output logic [DataWidth/8-1:0] mem_be_o,
   output logic [DataWidth-1:0]   mem_wdata_o,
   input  logic                   mem_rvalid_i,
   input  logic [DataWidth-1:0]   mem_rdata_i,
   // X-interface result
   output logic                   x_mem_result_valid_o,
   output logic [IdWidth-1:0]     x_mem_result_id_o,
   output logic [DataWidth-1:0]   x_mem_result_rdata_o,
   // Status
   output logic                   idle_o,
   output logic                   last_done_o
);

   localparam int unsigned CntWidth   = $clog2(NrOutstanding + 1);
   localparam int unsigned EntryWidth = IdWidth + 2;

   typedef struct packed {
      logic [IdWidth-1:0] id;
      logic               we;
      logic               last;
   } entry_t;

   logic [CntWidth-1:0]  count_q, count_d;
   logic                 full, accept, pop;
   logic                 fifo_empty, fifo_full;
   entry_t               push_entry, head;

   logic                 res_valid_q, res_valid_d;
   logic [IdWidth-1:0]   res_id_q, res_id_d;
   logic [DataWidth-1:0] res_rdata_q, res_rdata_d;
   logic                 last_done_q, last_done_d;

   // Full is taken from the registered count only, so a pop in the same cycle
   // cannot open the request path until the following cycle.
   assign full          = (count_q == CntWidth'(NrOutstanding));
   assign mem_req_o     = x_mem_valid_i & ~full;
   assign x_mem_ready_o = mem_gnt_i & ~full;
   assign accept        = x_mem_valid_i & x_mem_ready_o;
   // A response with nothing outstanding is dropped rather than underflowing.
   assign pop           = mem_rvalid_i & ~fifo_empty;
   assign idle_o        = (count_q == '0);

   // Request fields pass straight through; loads enable every byte lane.
   assign mem_addr_o  = req_addr_i;
   assign mem_we_o    = req_we_i;
   assign mem_wdata_o = req_wdata_i;
   assign mem_be_o    = req_we_i ? req_strb_i : '1;

   assign push_entry = '{id: req_id_i, we: req_we_i, last: req_last_i};

   spatz_xmem_responder_fifo #(
      .Depth (NrOutstanding),
      .Width (EntryWidth)
   ) i_tracking_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (accept),
      .data_i  (push_entry),
      .pop_i   (pop),
      .data_o  (head),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   // Outstanding counter next-state: a same-cycle accept and pop cancel out.
   always_comb begin
      count_d = count_q;
      unique case ({accept, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Result next-state: loads produce a result, any retiring last pulses done.
   always_comb begin
      res_valid_d = 1'b0;
      last_done_d = 1'b0;
      res_id_d    = res_id_q;
      res_rdata_d = res_rdata_q;
      if (pop) begin
         last_done_d = head.last;
         if (!head.we) begin
            res_valid_d = 1'b1;
            res_id_d    = head.id;
            res_rdata_d = mem_rdata_i;
         end
      end
   end

   // Counter and result registers; reset discards everything in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q     <= '0;
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_rdata_q <= '0;
         last_done_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         res_valid_q <= res_valid_d;
         res_id_q    <= res_id_d;
         res_rdata_q <= res_rdata_d;
         last_done_q <= last_done_d;
      end
   end

   assign x_mem_result_valid_o = res_valid_q;
   assign x_mem_result_id_o    = res_id_q;
   assign x_mem_result_rdata_o = res_rdata_q;
   assign last_done_o          = last_done_q;

   // A memory response with nothing outstanding is a protocol slip upstream.
   a_rvalid_without_request : assert property (
      @(posedge clk_i) disable iff (!rst_ni) mem_rvalid_i |-> !fifo_empty
   ) else $warning("mem_rvalid_i with empty tracking FIFO was ignored");

   // Accepting into a full tracker would lose an entry and wrap the counter.
   a_accept_at_full : assert property (
      @(posedge clk_i) disable iff (!rst_ni) accept |-> !fifo_full
   ) else $error("request accepted while tracking FIFO full");

endmodule
